// File: rtl/jam_cost_eval.sv
// Cost evaluation stage for the 8-worker job-assignment search: owns the current
// permutation, sums its ROM costs and tracks the minimum cost and its multiplicity.
module jam_cost_eval #(
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic [2:0]        perm_out0,
    output logic [2:0]        perm_out1,
    output logic [2:0]        perm_out2,
    output logic [2:0]        perm_out3,
    output logic [2:0]        perm_out4,
    output logic [2:0]        perm_out5,
    output logic [2:0]        perm_out6,
    output logic [2:0]        perm_out7,
    output logic              sort_start,
    input  logic [2:0]        perm_in0,
    input  logic [2:0]        perm_in1,
    input  logic [2:0]        perm_in2,
    input  logic [2:0]        perm_in3,
    input  logic [2:0]        perm_in4,
    input  logic [2:0]        perm_in5,
    input  logic [2:0]        perm_in6,
    input  logic [2:0]        perm_in7,
    input  logic              sort_done,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              Valid
);
    typedef enum logic [2:0] {ACC, CMP, REQ, WAIT_LO, WAIT_HI, FIN} state_t;

    // Element k of the permutation lives in slice [k].
    localparam logic [7:0][2:0] IDENT = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0] DESC  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    state_t            state_q;
    logic [7:0][2:0]   perm_q;
    logic [7:0][2:0]   perm_in_w;
    logic [2:0]        idx_q;
    logic [2:0]        j_q;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_d;
    logic [SUM_W-1:0]  min_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_q;
    logic              valid_q;

    assign perm_in_w = {perm_in7, perm_in6, perm_in5, perm_in4,
                        perm_in3, perm_in2, perm_in1, perm_in0};
    assign sum_d     = sum_q + {{(SUM_W-COST_W){1'b0}}, Cost};

    assign {perm_out7, perm_out6, perm_out5, perm_out4,
            perm_out3, perm_out2, perm_out1, perm_out0} = perm_q;

    // The ROM address is the registered index itself, so it is only 7 during the last ACC cycle.
    assign W          = idx_q;
    assign J          = j_q;
    assign sort_start = start_q;
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;
    assign Valid      = valid_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ACC;
            perm_q  <= IDENT;
            idx_q   <= 3'd0;
            j_q     <= 3'd0;
            sum_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    sum_q <= sum_d;
                    // idx wraps 7 -> 0, which also preloads the address for the next pass.
                    idx_q <= idx_q + 3'd1;
                    j_q   <= perm_q[idx_q + 3'd1];
                    if (idx_q == 3'd7)
                        state_q <= CMP;
                end
                CMP: begin
                    if (sum_q < min_q) begin
                        min_q <= sum_q;
                        cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (sum_q == min_q && cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    sum_q <= '0;
                    idx_q <= 3'd0;
                    if (perm_q == DESC) begin
                        state_q <= FIN;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= REQ;
                        start_q <= 1'b1;
                    end
                end
                REQ: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    // A sorter still showing done here has not yet accepted the request.
                    if (!sort_done)
                        state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (sort_done) begin
                        perm_q  <= perm_in_w;
                        j_q     <= perm_in_w[0];
                        idx_q   <= 3'd0;
                        state_q <= ACC;
                    end
                end
                FIN: begin
                    valid_q <= 1'b0;
                end
                default: state_q <= ACC;
            endcase
        end
    end
endmodule

// File: doc/jam_cost_eval.md
Name: jam_cost_eval

Overview:
- Evaluation stage paired with the 8-element next-permutation sorter for the job-assignment (JAM) problem.
- Owns the current worker-to-job permutation and feeds it to the sorter; reads the cost of each assignment from the external cost ROM and sums it.
- Tracks the minimum total cost and how many permutations achieve it, walking all 40320 permutations from ascending 0..7 to descending 7..0.
- Pulses Valid once when the walk completes.

Parameters:
COST_W, 7, width of one cost entry
SUM_W, 10, width of the accumulated and minimum cost (8*127 = 1016 fits)
CNT_W, 4, width of MatchCount; saturates at 2^CNT_W-1

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
W  output  3  worker index to cost ROM
J  output  3  job index to cost ROM
Cost  input  COST_W  ROM data for (W,J), combinational, valid in the same cycle W/J are driven
perm_out0..perm_out7  output  3 each  current permutation, to sorter arrange0..7
sort_start  output  1  one-cycle request for the next permutation
perm_in0..perm_in7  input  3 each  sorter arrange_out0..7
sort_done  input  1  sorter done; high while idle, low while working
MatchCount  output  CNT_W  number of permutations with cost equal to MinCost
MinCost  output  SUM_W  minimum total cost found
Valid  output  1  one-cycle pulse, results final

Behaviour:
- Reset (RST low, async) values:
  - perm = {0,1,2,3,4,5,6,7}; W=0, J=0; sort_start=0; Valid=0.
  - MinCost=all ones (1023); MatchCount=0; sum=0; idx=0; state=ACC.
- States: ACC, CMP, REQ, WAIT_LO, WAIT_HI, FIN.
- ACC (8 cycles, idx 0..7):
  - W=idx, J=perm[idx], both registered.
  - At the edge closing each cycle: sum += Cost, zero-extended.
  - idx==7 -> CMP.
- CMP (1 cycle):
  - sum < MinCost: MinCost=sum, MatchCount=1.
  - sum == MinCost: MatchCount+1, saturating at 15.
  - sum > MinCost: no change.
  - Then clear sum and idx. If perm == {7,6,5,4,3,2,1,0} -> FIN, else -> REQ.
- REQ: sort_start=1 for exactly this cycle; perm_out held stable -> WAIT_LO.
- WAIT_LO: stay until sort_done==0 (sorter accepted) -> WAIT_HI. sort_done high in REQ/WAIT_LO never counts as completion.
- WAIT_HI: stay until sort_done==1; capture perm_in0..7 into perm -> ACC, idx=0.
- FIN:
  - Valid=1 for the first FIN cycle only, then 0.
  - MinCost/MatchCount held; stays in FIN until reset.
- perm_out0..7 mirror the perm register at all times; the sorter samples them continuously while waiting.
- Per-permutation latency: 8 ACC + 1 CMP + 1 REQ + sorter turnaround. ACC always reads exactly 8 entries; no pruning.
- MinCost and MatchCount are observable mid-run. Only the Valid cycle is guaranteed final.
- Reset mid-run:
  - Restarts from the identity permutation and clears results.
  - Any in-flight sorter operation is abandoned; the sorter must be reset by the same RST domain.
- sort_start never asserts outside REQ.
- W/J are always driven to legal indices 0..7.

Test Plan:
- Cost(w,j)=1 for all entries, real sorter -> Valid pulses once after 40320 evaluations; MinCost=8; MatchCount=15 (saturated).
- Cost=0 on diagonal w==j, 100 elsewhere -> MinCost=0, MatchCount=1. MinCost equals 0 right after the first CMP and never changes.
- Cost(w,j)=w XOR j plus 10 when j==7-w -> bench reference model (brute force over all permutations) matches MinCost/MatchCount exactly at Valid.
- Stub sorter that returns {7,6,5,4,3,2,1,0} after 3 cycles of sort_done low:
  - Exactly two ACC passes, one sort_start pulse.
  - Valid asserts 1 cycle after the second CMP.
  - sort_start never asserts again.
- Stub holds sort_done=1 for 5 cycles after sort_start before dropping -> block remains in WAIT_LO, no perm capture until the low-then-high sequence completes.
- Assert RST low during the 3rd ACC cycle of the 100th permutation -> outputs immediately at reset values. After release, W/J sequence restarts at (0,0),(1,1)..(7,7).
